seg7_mux_decoder: RTL
=====================

# seg7_mux_decoder

Recovers the two displayed BCD digits from a multiplexed two-digit seven-segment drive: eight segment lines plus two digit-common lines, with selectable polarity. It is the receiving end of the dice display path and sits on the bench and monitor side of the design. It oversamples the display signals on its own fast clock, reassembles each ones/tens frame, and publishes a value only after that value is confirmed over consecutive frames.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a display phase is captured (≥2).
- `CONFIRM_FRAMES`, 2: consecutive identical frames required before publishing (≥1).
- `TIMEOUT_CYCLES`, 64: cycles without a ones capture before the display is declared blank.
- `clk` in 1: sampling clock; must be ≥8× the display mux rate.
- `rst` in 1: reset, asynchronous, active-high.
- `seg_in` in 8: segment lines, bit0=a … bit6=g, bit7=dp; asynchronous.
- `com_in` in 2: bit0=ones common, bit1=tens common; asynchronous.
- `seg_pol` in 1: 1 = segments active-high; quasi-static.
- `com_pol` in 1: 1 = commons active-high; quasi-static.
- `ones` out 4: published ones digit.
- `tens` out 4: published tens digit; 0 when the tens digit was blanked.
- `valid` out 1: published digits are current.
- `update` out 1: one-cycle pulse on the edge where `ones`/`tens` load.
- `blank` out 1: display dark longer than `TIMEOUT_CYCLES`.
- `err` out 1: one-cycle pulse on a protocol or decode error.

## Operation
- **Sync stage:** 2-flop synchronizer on `seg_in` and `com_in`. Reset values are inactive levels per the current polarity inputs. Samples are then normalized: XOR with ~pol, so logic 1 means lit or active.
- **Phase class** from normalized com:
  - 01 = ONES
  - 10 = TENS
  - 00 = DARK
  - 11 = ILLEGAL
- **Stability counter:** counts cycles where the normalized {com,seg} is unchanged and saturates at `STABLE_CYCLES`. Any change reloads it to 1.
- **Phase FSM:**
  - SEEK → HELD when the counter reaches `STABLE_CYCLES`; the capture happens on that edge.
  - HELD → SEEK on any sample change.
  - Exactly one capture per stable phase; DARK phases capture nothing.
- **Segment decode (g..a):**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D or 7C, 7=07 or 27, 8=7F, 9=6F or 67.
  - Any other pattern, or dp=1 in a ONES/TENS phase, is undecodable.
- **Frame assembly:**
  - A TENS capture stores `tens_pend` and sets `tens_seen`.
  - A ONES capture closes the frame as {tens_seen ? tens_pend : 0, ones digit}, then clears `tens_seen`.
  - Two TENS captures with no ONES between them: the last one wins.
- **Confirmation:**
  - `match_cnt` increments when the closed frame equals the previous frame; otherwise it is set to 1.
  - When `match_cnt` reaches `CONFIRM_FRAMES` and (frame ≠ published value or `valid`=0): load `ones`/`tens`, set `valid`, pulse `update`.
  - No republish on repeats of an already published value.
- **Errors:**
  - Triggers: an ILLEGAL phase captured, or an undecodable ONES/TENS capture.
  - Response: pulse `err`, discard the pending frame (clear `tens_seen`), reset `match_cnt` to 0.
  - Published outputs are unchanged.
- **Blank timeout:**
  - The counter resets on every ONES capture.
  - When it reaches `TIMEOUT_CYCLES`: set `blank`, clear `valid`, reset `match_cnt`.
  - `blank` clears on the next ONES capture.
- **Reset:** clears all state in every FSM state.
  - `ones`=0, `tens`=0, `valid`=0, `update`=0, `blank`=0, `err`=0.
  - Phase FSM = SEEK; counters = 0.
  - No capture until a full `STABLE_CYCLES` window has been seen after release.

## Timing
- Capture latency: pin change → capture edge = 2 (sync) + `STABLE_CYCLES` cycles.
- `update`, `ones`, `tens`, `valid` all change on the edge after the confirming ONES capture. `update` is high exactly 1 cycle.
- `err` asserts on the edge after the offending capture, for 1 cycle.
- `blank` and `valid`=0 assert on the edge where the timeout counter reaches `TIMEOUT_CYCLES`.
- A phase shorter than `STABLE_CYCLES` samples (glitch) is ignored entirely.
- Simultaneous timeout and ONES capture: the capture wins and the timeout counter reloads.
- Polarity inputs change mid-frame: the resulting sample change restarts stability. Bench must hold polarity ≥1 frame before checking.

## Test plan
- **Two digits:** pol=1/1; alternate ONES seg=5B and TENS seg=66, 16 cycles each, for 3 frames → `update` pulses once after frame 2 with tens=4, ones=2, `valid`=1; no further pulses.
- **Blanked tens:** ONES seg=07 alternating with DARK (com=00) → tens=0, ones=7, `valid`=1.
- **Inverted polarity:** seg_pol=0, com_pol=0, pins driven inverted for value 19 → tens=1, ones=9; glitch pulses of 2 cycles injected mid-phase cause no `err` and no change.
- **Errors:** ONES seg=49 → `err` pulse, outputs hold. com=11 stable → `err` pulse. Next two clean frames of 35 → publish 35.
- **Timeout:** after publishing 12, hold com=00 for 64 cycles → `blank`=1, `valid`=0; resume value 12 → `blank`=0, `update` after 2 frames, `valid`=1.
- **Reset:** assert `rst` mid-TENS phase → all outputs 0 immediately. Release → first publish only after 2 full frames.

Source files
------------

// File: rtl/seg7_mux_decoder.sv
// seg7_mux_decoder
// Receives a multiplexed two-digit seven-segment drive (8 segment lines plus
// ones/tens commons), oversamples it on the local clock, reassembles each
// tens/ones frame and publishes the BCD value once it has been seen on
// CONFIRM_FRAMES consecutive frames. A display that stays dark for
// TIMEOUT_CYCLES without a ones phase is reported as blank.

module seg7_mux_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int CONFIRM_FRAMES = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [1:0] com_in,
    input  logic       seg_pol,
    input  logic       com_pol,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       valid,
    output logic       update,
    output logic       blank,
    output logic       err
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int CONF_W = $clog2(CONFIRM_FRAMES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM_FRAMES);
    localparam logic [CONF_W-1:0] CONF_ONE = CONF_W'(1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);

    typedef enum logic {
        SEEK,
        HELD
    } phase_state_t;

    // Normalized com pattern: bit0 = ones common active, bit1 = tens common.
    typedef enum logic [1:0] {
        CLS_DARK    = 2'b00,
        CLS_ONES    = 2'b01,
        CLS_TENS    = 2'b10,
        CLS_ILLEGAL = 2'b11
    } phase_class_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] digit;
    } decode_t;

    // Maps a normalized segment pattern (dp,g..a) to a BCD digit. Both the
    // tailed and untailed shapes of 6, 7 and 9 are accepted; a lit dp or any
    // unknown shape is undecodable.
    function automatic decode_t decode_seg(input logic [7:0] s);
        decode_t d;
        d.ok    = 1'b1;
        d.digit = 4'd0;
        if (s[7]) begin
            d.ok = 1'b0;
        end else begin
            case (s[6:0])
                7'h3F:        d.digit = 4'd0;
                7'h06:        d.digit = 4'd1;
                7'h5B:        d.digit = 4'd2;
                7'h4F:        d.digit = 4'd3;
                7'h66:        d.digit = 4'd4;
                7'h6D:        d.digit = 4'd5;
                7'h7D, 7'h7C: d.digit = 4'd6;
                7'h07, 7'h27: d.digit = 4'd7;
                7'h7F:        d.digit = 4'd8;
                7'h6F, 7'h67: d.digit = 4'd9;
                default:      d.ok    = 1'b0;
            endcase
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [7:0] seg_meta, seg_sync;
    logic [1:0] com_meta, com_sync;

    // Two-flop synchronizer; resets to the inactive pin level so the
    // normalized view starts dark.
    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta <= {8{~seg_pol}};
            seg_sync <= {8{~seg_pol}};
            com_meta <= {2{~com_pol}};
            com_sync <= {2{~com_pol}};
        end else begin
            seg_meta <= seg_in;
            seg_sync <= seg_meta;
            com_meta <= com_in;
            com_sync <= com_meta;
        end
    end

    // After normalization a 1 always means "lit" or "common active".
    logic [7:0]   seg_norm;
    logic [1:0]   com_norm;
    logic [9:0]   sample;
    phase_class_t sample_cls;

    assign seg_norm   = seg_sync ^ {8{~seg_pol}};
    assign com_norm   = com_sync ^ {2{~com_pol}};
    assign sample     = {com_norm, seg_norm};
    assign sample_cls = phase_class_t'(com_norm);

    // ------------------------------------------------------------------
    // Stability counter and phase FSM
    // ------------------------------------------------------------------
    phase_state_t      state, state_next;
    logic [STAB_W-1:0] stab_cnt, stab_cnt_next;
    logic [9:0]        prev_sample;
    logic [9:0]        held_sample;
    logic              changed;
    logic              capture_now;

    // Next-state logic: a phase is captured when it has been stable for
    // STABLE_CYCLES samples. A sample equal to the last held phase is not
    // captured again, so a short glitch inside a phase cannot split it into
    // two captures.
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next    = state;
        capture_now   = 1'b0;
        changed       = (sample != prev_sample);
        stab_cnt_next = stab_cnt;
        if (changed) begin
            stab_cnt_next = STAB_ONE;
        end else if (stab_cnt < STAB_MAX) begin
            stab_cnt_next = stab_cnt + STAB_ONE;
        end
        case (state)
            SEEK: begin
                if (!changed && stab_cnt_next == STAB_MAX) begin
                    state_next  = HELD;
                    capture_now = (sample != held_sample);
                end
            end
            HELD: begin
                if (changed) begin
                    state_next = SEEK;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    // Phase FSM state, stability counter and the last held phase pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEEK;
            stab_cnt    <= '0;
            prev_sample <= '0;
            held_sample <= '0;
        end else begin
            state       <= state_next;
            stab_cnt    <= stab_cnt_next;
            prev_sample <= sample;
            if (state == SEEK && state_next == HELD) begin
                held_sample <= sample;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture register: one cycle of pipeline between the capture edge and
    // the frame/confirm logic.
    // ------------------------------------------------------------------
    logic         cap_pulse;
    phase_class_t cap_cls;
    logic [7:0]   cap_seg;
    logic         ones_capture_now;

    assign ones_capture_now = capture_now && (sample_cls == CLS_ONES);

    // Latch the captured phase; dark phases produce no capture event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pulse <= 1'b0;
            cap_cls   <= CLS_DARK;
            cap_seg   <= '0;
        end else begin
            cap_pulse <= capture_now && (sample_cls != CLS_DARK);
            if (capture_now) begin
                cap_cls <= sample_cls;
                cap_seg <= seg_norm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blank timeout
    // ------------------------------------------------------------------
    logic [TO_W-1:0] to_cnt, to_cnt_next;
    logic            timeout_hit;

    // A ones capture always reloads the counter, so it beats a timeout that
    // would otherwise land on the same edge.
    always_comb begin
        to_cnt_next = to_cnt;
        if (ones_capture_now) begin
            to_cnt_next = '0;
        end else if (to_cnt < TO_MAX) begin
            to_cnt_next = to_cnt + TO_ONE;
        end
        timeout_hit = (to_cnt != TO_MAX) && (to_cnt_next == TO_MAX);
    end

    // Cycles since the last ones capture, saturating at TIMEOUT_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly and confirmation
    // ------------------------------------------------------------------
    logic [3:0]        tens_pend;
    logic              tens_seen;
    logic [7:0]        prev_frame;
    logic [CONF_W-1:0] match_cnt, match_next;
    decode_t           dec;
    logic              cap_ones, cap_tens, cap_error, frame_close, publish;
    logic [7:0]        frame;

    // Decode the captured phase and decide whether the closing frame
    // publishes a new value.
    always_comb begin
        dec         = decode_seg(cap_seg);
        cap_ones    = cap_pulse && (cap_cls == CLS_ONES);
        cap_tens    = cap_pulse && (cap_cls == CLS_TENS);
        cap_error   = cap_pulse && ((cap_cls == CLS_ILLEGAL) || !dec.ok);
        frame_close = cap_ones && dec.ok;
        frame       = {(tens_seen ? tens_pend : 4'd0), dec.digit};
        match_next  = CONF_ONE;
        if (frame == prev_frame) begin
            match_next = (match_cnt < CONF_MAX) ? match_cnt + CONF_ONE : match_cnt;
        end
        publish = frame_close && (match_next == CONF_MAX) &&
                  ((frame != {tens, ones}) || !valid);
    end

    // Frame state, published outputs, error pulse and blank flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_pend  <= '0;
            tens_seen  <= 1'b0;
            prev_frame <= '0;
            match_cnt  <= '0;
            ones       <= '0;
            tens       <= '0;
            valid      <= 1'b0;
            update     <= 1'b0;
            blank      <= 1'b0;
            err        <= 1'b0;
        end else begin
            update <= publish;
            err    <= cap_error;

            if (cap_error) begin
                tens_seen <= 1'b0;
                match_cnt <= '0;
            end else if (cap_tens) begin
                tens_pend <= dec.digit;
                tens_seen <= 1'b1;
            end else if (frame_close) begin
                tens_seen  <= 1'b0;
                prev_frame <= frame;
                match_cnt  <= match_next;
                if (publish) begin
                    tens  <= frame[7:4];
                    ones  <= frame[3:0];
                    valid <= 1'b1;
                end
            end

            if (ones_capture_now) begin
                blank <= 1'b0;
            end else if (timeout_hit) begin
                blank     <= 1'b1;
                valid     <= 1'b0;
                match_cnt <= '0;
            end
        end
    end

endmodule
